ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_3000, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter TIMEOUT, default 15, giving the maximum cycles to wait for mem_ack (range 1..15).
REQ-003 The module SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  leave IDLE and begin fetching
- mem_req  out  1  instruction-memory read request
- mem_addr  out  32  read address (= pc)
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  instruction word
- ins_out  out  32  latched instruction, feeds IR ins_in
- ir_wr  out  1  one-cycle IR write strobe
- ins_valid  out  1  ins_out held and awaiting consumer
- next  in  1  consumer done; advance PC
- jmp  in  1  take jump on advance
- jmp_imm26  in  26  jump target field
- br_taken  in  1  take branch on advance
- br_imm16  in  16  branch offset field
- pc_out  out  32  PC of instruction in ins_out
- fault  out  1  sticky memory-timeout flag

Function
REQ-005 States SHALL be IDLE, FETCH, HOLD, ERR, encoded as 2 bits.
REQ-006 In IDLE, start=1 SHALL move to FETCH on the next edge; other inputs SHALL be ignored.
REQ-007 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; in all other states mem_req SHALL be 0.
REQ-008 In FETCH with mem_ack=1, the block SHALL on that edge: latch mem_rdata into ins_out; set pc_out<=pc; assert ir_wr for exactly the following cycle; move to HOLD.
REQ-009 Latency from FETCH entry to ir_wr high SHALL be (cycles until mem_ack)+1; a same-cycle ack SHALL give ir_wr one cycle after FETCH entry.
REQ-010 ins_valid SHALL be 1 exactly while in HOLD; ins_out SHALL remain stable throughout HOLD.
REQ-011 In HOLD with next=1, pc SHALL update on that edge, with priority jmp > br_taken > sequential:
- jmp: pc <= {pc_plus4[31:28], jmp_imm26, 2'b00}
- br_taken: pc <= pc_plus4 + ({{14{br_imm16[15]}}, br_imm16, 2'b00})
- else: pc <= pc + 4
Then the state SHALL move to FETCH.
REQ-012 All PC arithmetic SHALL be modulo 2^32; pc=32'hFFFF_FFFC sequential SHALL wrap to 32'h0000_0000.
REQ-013 jmp, br_taken and the immediates SHALL be sampled only on the HOLD edge where next=1; they SHALL be ignored otherwise.
REQ-014 next outside HOLD and mem_ack outside FETCH SHALL be ignored.
REQ-015 A 4-bit wait counter SHALL clear on FETCH entry and increment each FETCH cycle without mem_ack.
REQ-016 If the counter reaches TIMEOUT without mem_ack, the state SHALL move to ERR; mem_ack in that same cycle SHALL take precedence (normal REQ-008 path).
REQ-017 In ERR, fault SHALL be 1 and mem_req, ir_wr and ins_valid SHALL be 0; only rst exits ERR.

Reset
REQ-018 With rst=1 at a rising edge, the block SHALL enter IDLE with pc=RESET_PC, pc_out=RESET_PC, ins_out=0, counter=0.
REQ-019 After that edge, ir_wr, ins_valid, mem_req and fault SHALL all be 0.
REQ-020 rst SHALL dominate all other inputs, including mid-FETCH with mem_ack=1, HOLD with next=1, and ERR.
REQ-021 A mem_ack arriving after a mid-FETCH reset SHALL be ignored.

Verification
REQ-022 Reset, start, mem_ack on the 2nd FETCH cycle with rdata 32'h2008_0005 -> mem_addr=32'h0000_3000; ir_wr single pulse; ins_out=32'h2008_0005; pc_out=32'h0000_3000; ins_valid=1.
REQ-023 HOLD at pc 32'h0000_3000; next with br_taken=1, br_imm16=16'hFFFF -> next mem_addr=32'h0000_3000; with br_imm16=16'h0004 -> 32'h0000_3014.
REQ-024 HOLD at pc 32'h0000_3004; next with jmp=1, br_taken=1, jmp_imm26=26'h0000C10 -> mem_addr=32'h0000_3040 (jump wins).
REQ-025 RESET_PC=32'hFFFF_FFFC; fetch, then next with no redirect -> mem_addr=32'h0000_0000.
REQ-026 mem_ack held low for 15 FETCH cycles -> fault=1, mem_req=0; later mem_ack and next have no effect; rst -> fault=0, state IDLE.
REQ-027 rst asserted in the same cycle as mem_ack in FETCH -> no ir_wr pulse; ins_out=0; pc=RESET_PC.

Source files
------------

// File: rtl/ins_fetch.sv
// ins_fetch -- instruction fetch unit.
//
// Reads an instruction word from instruction memory at the current PC. It
// latches the word for the instruction register and holds it until the
// consumer signals 'next'. The PC then advances sequentially, by a
// PC-relative branch, or by a region jump. If memory does not acknowledge a
// read within TIMEOUT cycles, the unit parks in a sticky fault state until
// reset.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               leave IDLE and begin fetching
//   mem_req, mem_addr   instruction-memory read request and address (= pc)
//   mem_ack, mem_rdata  read data valid strobe and instruction word
//   ins_out, ir_wr      latched instruction and one-cycle IR write strobe
//   ins_valid           ins_out held and awaiting the consumer
//   next                consumer done; advance the PC
//   jmp, jmp_imm26      jump request and target field
//   br_taken, br_imm16  branch request and word offset field
//   pc_out              PC of the instruction currently in ins_out
//   fault               sticky memory-timeout flag
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ins_out,
  output logic        ir_wr,
  output logic        ins_valid,
  input  logic        next,
  input  logic        jmp,
  input  logic [25:0] jmp_imm26,
  input  logic        br_taken,
  input  logic [15:0] br_imm16,
  output logic [31:0] pc_out,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    ERR   = 2'b11
  } state_e;

  // The wait counter sits at this value during the last FETCH cycle that
  // may still receive an ack before the unit gives up.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_out_q;
  logic [31:0] ins_q;
  logic        ir_wr_q;
  logic [3:0]  wait_q;

  logic [31:0] pc_plus4_s;
  logic [31:0] br_off_s;
  logic [31:0] pc_d;

  // Next-PC selection for a HOLD-state advance: jump beats branch beats sequential.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    br_off_s   = {{14{br_imm16[15]}}, br_imm16, 2'b00};
    pc_d       = pc_plus4_s;
    if (jmp) begin
      pc_d = {pc_plus4_s[31:28], jmp_imm26, 2'b00};
    end else if (br_taken) begin
      pc_d = pc_plus4_s + br_off_s;
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  // Fetch state machine together with the PC, instruction latch, strobe and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      ins_q    <= 32'h0000_0000;
      ir_wr_q  <= 1'b0;
      wait_q   <= 4'd0;
    end else begin
      // ir_wr is a single-cycle pulse; only the ack branch re-arms it.
      ir_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            wait_q  <= 4'd0;
          end
        end
        FETCH: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem_ack) begin
            ins_q    <= mem_rdata;
            pc_out_q <= pc_q;
            ir_wr_q  <= 1'b1;
            state_q  <= HOLD;
          end else if (wait_q == WAIT_LAST) begin
            wait_q  <= wait_q + 4'd1;
            state_q <= ERR;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        HOLD: begin
          if (next) begin
            pc_q    <= pc_d;
            wait_q  <= 4'd0;
            state_q <= FETCH;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The following outputs decode the state register, so none of them has a
  // combinational path from an input.
  assign mem_req   = (state_q == FETCH);
  assign mem_addr  = pc_q;
  assign ins_valid = (state_q == HOLD);
  assign fault     = (state_q == ERR);
  assign ir_wr     = ir_wr_q;
  assign ins_out   = ins_q;
  assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed-vector bench for ins_fetch. A second instance, built with
// RESET_PC = 32'hFFFF_FFFC, shares the inputs and checks that the PC wraps.
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        next = 1'b0;
  logic        jmp = 1'b0;
  logic [25:0] jmp_imm26 = 26'h0;
  logic        br_taken = 1'b0;
  logic [15:0] br_imm16 = 16'h0;

  logic        mem_req, ir_wr, ins_valid, fault;
  logic [31:0] mem_addr, ins_out, pc_out;
  logic        w_mem_req, w_ir_wr, w_ins_valid, w_fault;
  logic [31:0] w_mem_addr, w_ins_out, w_pc_out;

  int n_cmp = 0;
  int n_bad = 0;

  ins_fetch dut (
    .clk(clk), .rst(rst), .start(start), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins_out(ins_out), .ir_wr(ir_wr),
    .ins_valid(ins_valid), .next(next), .jmp(jmp), .jmp_imm26(jmp_imm26),
    .br_taken(br_taken), .br_imm16(br_imm16), .pc_out(pc_out), .fault(fault)
  );

  ins_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins_out(w_ins_out), .ir_wr(w_ir_wr),
    .ins_valid(w_ins_valid), .next(next), .jmp(jmp), .jmp_imm26(jmp_imm26),
    .br_taken(br_taken), .br_imm16(br_imm16), .pc_out(w_pc_out), .fault(w_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1; step();
    rst = 1'b0;
    check_eq("rst_mem_req",   32'(mem_req),   32'd0);
    check_eq("rst_ir_wr",     32'(ir_wr),     32'd0);
    check_eq("rst_ins_valid", 32'(ins_valid), 32'd0);
    check_eq("rst_fault",     32'(fault),     32'd0);
    check_eq("rst_ins_out",   ins_out,        32'h0);
    check_eq("rst_pc_out",    pc_out,         32'h0000_3000);
    check_eq("rst_mem_addr",  mem_addr,       32'h0000_3000);

    // Idle ignores ack and next
    mem_ack = 1'b1; next = 1'b1; step();
    mem_ack = 1'b0; next = 1'b0;
    check_eq("idle_ignore_req",  32'(mem_req), 32'd0);
    check_eq("idle_ignore_irwr", 32'(ir_wr),   32'd0);

    // Basic fetch, ack on the 2nd FETCH cycle
    start = 1'b1; step(); start = 1'b0;
    check_eq("f1_mem_req",  32'(mem_req), 32'd1);
    check_eq("f1_mem_addr", mem_addr,     32'h0000_3000);
    step();
    check_eq("f2_mem_req",  32'(mem_req), 32'd1);
    check_eq("f2_ir_wr",    32'(ir_wr),   32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005; step(); mem_ack = 1'b0;
    check_eq("f_ir_wr",     32'(ir_wr),     32'd1);
    check_eq("f_ins_valid", 32'(ins_valid), 32'd1);
    check_eq("f_ins_out",   ins_out,        32'h2008_0005);
    check_eq("f_pc_out",    pc_out,         32'h0000_3000);
    check_eq("f_mem_req",   32'(mem_req),   32'd0);
    step();
    check_eq("f_ir_wr_pulse", 32'(ir_wr),     32'd0);
    check_eq("f_hold_valid",  32'(ins_valid), 32'd1);

    // ack during HOLD must not disturb ins_out
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; step(); mem_ack = 1'b0;
    check_eq("hold_ack_ignored", ins_out, 32'h2008_0005);
    check_eq("hold_ack_irwr",    32'(ir_wr), 32'd0);

    // Backward branch: 3004 + (-4) = 3000
    next = 1'b1; br_taken = 1'b1; br_imm16 = 16'hFFFF; step();
    next = 1'b0; br_taken = 1'b0; br_imm16 = 16'h0;
    check_eq("brn_mem_addr",  mem_addr,        32'h0000_3000);
    check_eq("brn_mem_req",   32'(mem_req),    32'd1);
    check_eq("brn_ins_valid", 32'(ins_valid),  32'd0);

    // Same-cycle ack gives ir_wr one cycle after FETCH entry
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222; step(); mem_ack = 1'b0;
    check_eq("fast_ir_wr",   32'(ir_wr), 32'd1);
    check_eq("fast_ins_out", ins_out,    32'h1111_2222);

    // Forward branch: 3004 + 0x10 = 3014
    next = 1'b1; br_taken = 1'b1; br_imm16 = 16'h0004; step();
    next = 1'b0; br_taken = 1'b0; br_imm16 = 16'h0;
    check_eq("brp_mem_addr", mem_addr, 32'h0000_3014);

    // next/jmp during FETCH are ignored
    next = 1'b1; jmp = 1'b1; jmp_imm26 = 26'h3FF_FFFF; step();
    next = 1'b0; jmp = 1'b0; jmp_imm26 = 26'h0;
    check_eq("fetch_next_addr", mem_addr,     32'h0000_3014);
    check_eq("fetch_next_req",  32'(mem_req), 32'd1);

    // Reset beats a same-cycle ack in FETCH
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; rst = 1'b1; step(); rst = 1'b0;
    check_eq("rstack_ir_wr",   32'(ir_wr),   32'd0);
    check_eq("rstack_ins_out", ins_out,      32'h0);
    check_eq("rstack_addr",    mem_addr,     32'h0000_3000);
    check_eq("rstack_req",     32'(mem_req), 32'd0);
    step(); mem_ack = 1'b0;
    check_eq("late_ack_irwr",  32'(ir_wr),   32'd0);
    check_eq("late_ack_ins",   ins_out,      32'h0);

    // Sequential advance, and wrap on the second instance
    start = 1'b1; step(); start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0001; step(); mem_ack = 1'b0;
    check_eq("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
    next = 1'b1; step(); next = 1'b0;
    check_eq("seq_mem_addr",  mem_addr,   32'h0000_3004);
    check_eq("wrap_mem_addr", w_mem_addr, 32'h0000_0000);

    // Jump wins over branch: {3008[31:28], C10, 00} = 3040
    mem_ack = 1'b1; mem_rdata = 32'h0000_0002; step(); mem_ack = 1'b0;
    check_eq("jmp_pc_out", pc_out, 32'h0000_3004);
    next = 1'b1; jmp = 1'b1; br_taken = 1'b1; jmp_imm26 = 26'h0000C10; br_imm16 = 16'h0004; step();
    next = 1'b0; jmp = 1'b0; br_taken = 1'b0; jmp_imm26 = 26'h0; br_imm16 = 16'h0;
    check_eq("jmp_mem_addr", mem_addr, 32'h0000_3040);

    // Timeout: 15 unacknowledged FETCH cycles -> ERR
    for (int i = 0; i < 14; i++) step();
    check_eq("to_15th_req",   32'(mem_req), 32'd1);
    check_eq("to_15th_fault", 32'(fault),   32'd0);
    step();
    check_eq("to_fault",     32'(fault),     32'd1);
    check_eq("to_req",       32'(mem_req),   32'd0);
    check_eq("to_ins_valid", 32'(ins_valid), 32'd0);
    mem_ack = 1'b1; next = 1'b1; start = 1'b1; step(); step();
    mem_ack = 1'b0; next = 1'b0; start = 1'b0;
    check_eq("err_sticky_fault", 32'(fault), 32'd1);
    check_eq("err_sticky_req",   32'(mem_req), 32'd0);
    check_eq("err_sticky_irwr",  32'(ir_wr), 32'd0);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("err_rst_fault", 32'(fault),   32'd0);
    check_eq("err_rst_req",   32'(mem_req), 32'd0);
    check_eq("err_rst_addr",  mem_addr,     32'h0000_3000);

    // Ack on the last allowed cycle takes precedence over the timeout
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; step(); mem_ack = 1'b0;
    check_eq("lastack_irwr",  32'(ir_wr), 32'd1);
    check_eq("lastack_fault", 32'(fault), 32'd0);
    check_eq("lastack_ins",   ins_out,    32'h0BAD_F00D);

    // Reset beats next in HOLD
    rst = 1'b1; next = 1'b1; step(); rst = 1'b0; next = 1'b0;
    check_eq("rsthold_valid", 32'(ins_valid), 32'd0);
    check_eq("rsthold_addr",  mem_addr,       32'h0000_3000);
    check_eq("rsthold_ins",   ins_out,        32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
